// File: rtl/qspi_bus_arbiter.sv
// Shared QSPI bus sequencer: round-robin between fetch and load/store ports,
// serialising command, address, dummy and data nibbles to flash / RAM A / RAM B.
//
// state   | meaning
// IDLE    | no select asserted, arbitrating
// CMD     | 2 command nibbles, high first
// ADDR    | 6 address nibbles, MSB first
// DUMMY   | read turnaround nibbles, bus released
// DATA    | 2 nibbles per byte, addr+0 first
// DONE    | select released, ready pulse follows
module qspi_bus_arbiter #(
  parameter int         FLASH_DUMMY = 4,
  parameter int         RAM_DUMMY   = 6,
  parameter logic [7:0] CMD_READ    = 8'hEB,
  parameter logic [7:0] CMD_WRITE   = 8'h38
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req,
  input  logic [24:0] instr_addr,
  output logic        instr_ready,
  output logic [31:0] instr_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic [24:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  input  logic [3:0]  spi_data_in,
  output logic [3:0]  spi_data_out,
  output logic [3:0]  spi_data_oe,
  output logic        spi_clk_out,
  output logic        spi_flash_select,
  output logic        spi_ram_a_select,
  output logic        spi_ram_b_select,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

  localparam logic [4:0] FLASH_DUMMY_N = 5'(FLASH_DUMMY);
  localparam logic [4:0] RAM_DUMMY_N   = 5'(RAM_DUMMY);

  state_t      state, nxt_state;
  logic [4:0]  cnt, nxt_cnt;
  logic        phase;
  logic        last_instr;
  logic        lat_instr, lat_we;
  logic [2:0]  lat_nbytes;
  logic [24:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rx;

  logic        d_ok, i_ok, pick_instr;
  logic [24:0] g_addr;
  logic        g_we;
  logic [7:0]  g_cmd;
  logic [23:0] bus_addr;
  logic [4:0]  dummy_n, data_last;
  logic [7:0]  cmd_byte;
  logic [3:0]  nib_val;
  logic        nib_drive;

  assign busy = (state != S_IDLE);

  // A port whose ready is showing still holds req for this cycle; skip it.
  always_comb begin
    d_ok       = data_req & ~data_ready;
    i_ok       = instr_req & ~instr_ready;
    pick_instr = i_ok & (~d_ok | ~last_instr);
    g_addr     = pick_instr ? instr_addr : data_addr;
    g_we       = ~pick_instr & data_we;
    g_cmd      = g_we ? CMD_WRITE : CMD_READ;
  end

  always_comb begin
    bus_addr  = lat_addr[24] ? {1'b0, lat_addr[22:0]} : lat_addr[23:0];
    dummy_n   = lat_addr[24] ? RAM_DUMMY_N : FLASH_DUMMY_N;
    data_last = {1'b0, lat_nbytes, 1'b0} - 5'd1;
    cmd_byte  = lat_we ? CMD_WRITE : CMD_READ;
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 5'd1;
    case (state)
      S_CMD: if (cnt == 5'd1) begin
        nxt_state = S_ADDR;
        nxt_cnt   = '0;
      end
      S_ADDR: if (cnt == 5'd5) begin
        nxt_state = (lat_we || dummy_n == 5'd0) ? S_DATA : S_DUMMY;
        nxt_cnt   = '0;
      end
      S_DUMMY: if (cnt == dummy_n - 5'd1) begin
        nxt_state = S_DATA;
        nxt_cnt   = '0;
      end
      S_DATA: if (cnt == data_last) begin
        nxt_state = S_DONE;
        nxt_cnt   = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    nib_val   = 4'h0;
    nib_drive = 1'b0;
    case (nxt_state)
      S_CMD: begin
        nib_val   = nxt_cnt[0] ? cmd_byte[3:0] : cmd_byte[7:4];
        nib_drive = 1'b1;
      end
      S_ADDR: begin
        nib_val   = 4'(bus_addr >> (5'd20 - {nxt_cnt[2:0], 2'b00}));
        nib_drive = 1'b1;
      end
      S_DATA: if (lat_we) begin
        nib_val   = lat_wdata[{nxt_cnt[2:1], ~nxt_cnt[0], 2'b00} +: 4];
        nib_drive = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      phase            <= 1'b0;
      last_instr       <= 1'b1;
      lat_instr        <= 1'b0;
      lat_we           <= 1'b0;
      lat_nbytes       <= '0;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      rx               <= '0;
      instr_ready      <= 1'b0;
      instr_data       <= '0;
      data_ready       <= 1'b0;
      data_rdata       <= '0;
      spi_data_out     <= '0;
      spi_data_oe      <= '0;
      spi_clk_out      <= 1'b0;
      spi_flash_select <= 1'b1;
      spi_ram_a_select <= 1'b1;
      spi_ram_b_select <= 1'b1;
    end else begin
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      case (state)
        S_IDLE: if (d_ok || i_ok) begin
          last_instr <= pick_instr;
          lat_instr  <= pick_instr;
          lat_addr   <= g_addr;
          lat_we     <= g_we;
          lat_wdata  <= data_wdata;
          lat_nbytes <= (pick_instr || data_size[1]) ? 3'd4 :
                        (data_size[0] ? 3'd2 : 3'd1);
          rx         <= '0;
          cnt        <= '0;
          phase      <= 1'b0;
          if (g_we && !g_addr[24]) begin
            state <= S_DONE;
          end else begin
            state            <= S_CMD;
            spi_flash_select <= g_addr[24];
            spi_ram_a_select <= ~(g_addr[24] & ~g_addr[23]);
            spi_ram_b_select <= ~(g_addr[24] & g_addr[23]);
            spi_data_out     <= g_cmd[7:4];
            spi_data_oe      <= 4'hF;
            spi_clk_out      <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (lat_instr) begin
            instr_ready <= 1'b1;
            instr_data  <= rx;
          end else begin
            data_ready <= 1'b1;
            if (!lat_we) data_rdata <= rx;
          end
        end
        default: begin
          if (!phase) begin
            phase       <= 1'b1;
            spi_clk_out <= 1'b1;
          end else begin
            phase       <= 1'b0;
            spi_clk_out <= 1'b0;
            if (state == S_DATA && !lat_we)
              rx[{cnt[2:1], ~cnt[0], 2'b00} +: 4] <= spi_data_in;
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (nxt_state == S_DONE) begin
              spi_flash_select <= 1'b1;
              spi_ram_a_select <= 1'b1;
              spi_ram_b_select <= 1'b1;
              spi_data_out     <= '0;
              spi_data_oe      <= '0;
            end else begin
              spi_data_out <= nib_val;
              spi_data_oe  <= nib_drive ? 4'hF : 4'h0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/qspi_bus_arbiter.md
Name: qspi_bus_arbiter

Overview:
Sequences the single shared QSPI bus (flash, RAM A, RAM B) for the CPU.
- Arbitrates between an instruction-fetch port and a data load/store port.
- Serialises command, address, dummy and data nibbles onto the bus.
- Drives the three active-low chip selects.
- Returns read data, or completes writes, with a one-cycle ready pulse.

Parameters:
- FLASH_DUMMY, 4, dummy nibble-clocks after the address for flash reads.
- RAM_DUMMY, 6, dummy nibble-clocks after the address for RAM reads.
- CMD_READ, 8'hEB, quad read command byte (flash and RAM).
- CMD_WRITE, 8'h38, quad write command byte (RAM only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- instr_req  in  1  fetch request; held until instr_ready
- instr_addr  in  25  fetch byte address
- instr_ready  out  1  one-cycle pulse; instr_data valid in that cycle
- instr_data  out  32  fetched word; first byte in [7:0]
- data_req  in  1  load/store request; held until data_ready
- data_we  in  1  1 = write
- data_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
- data_addr  in  25  byte address
- data_wdata  in  32  write data; first byte in [7:0]
- data_ready  out  1  one-cycle completion pulse
- data_rdata  out  32  read data; unread bytes zero
- spi_data_in  in  4  quad data from pins
- spi_data_out  out  4  quad data to pins
- spi_data_oe  out  4  pin output enable, 1 = drive
- spi_clk_out  out  1  SPI clock
- spi_flash_select  out  1  flash CS, active low
- spi_ram_a_select  out  1  RAM A CS, active low
- spi_ram_b_select  out  1  RAM B CS, active low
- busy  out  1  high whenever state is not IDLE

Behaviour:
Reset (rst_n low at a clk edge):
- All selects 1; spi_clk_out 0; spi_data_oe 0; spi_data_out 0.
- ready outputs 0; rdata/data outputs 0; state IDLE; round-robin pointer favours data.
- Reset mid-transaction aborts it; no ready pulse is issued and the request is lost.

Address decode:
- addr[24] = 0: flash; 24-bit address sent is addr[23:0].
- addr[24] = 1: RAM; addr[23] = 0 selects RAM A, 1 selects RAM B; address sent is {0, addr[22:0]}.

Arbitration (IDLE only):
- One pending request: grant it.
- Both pending: grant the port not granted last (round robin).
- On grant, latch addr, we, size and wdata. The request must stay high until ready; inputs are not resampled after the grant.

Flash write:
- No bus activity. State DONE is entered directly; ready pulses on the next cycle.

Nibble clock:
- Each nibble takes 2 clk cycles: phase 0 with spi_clk_out = 0, phase 1 with spi_clk_out = 1.
- spi_data_out changes only when entering phase 0.
- spi_data_in is sampled on the clk edge that ends phase 1.

States:
- IDLE: no select asserted.
- CMD: 2 nibbles, high nibble first; oe = 4'hF.
- ADDR: 6 nibbles, MSB nibble first; oe = 4'hF.
- DUMMY: reads only, FLASH_DUMMY or RAM_DUMMY nibbles; oe = 0.
- DATA: 2 x bytes nibbles; byte order addr+0 first, high nibble first within each byte; oe = 4'hF for writes, 0 for reads.
- DONE: 1 cycle; select deasserted, spi_clk_out 0, ready pulsed, return to IDLE.

Select timing:
- Select asserts in the first CMD cycle.
- It is deasserted on entry to DONE.
- DONE followed by IDLE guarantees at least 2 cycles of CS high between transactions.

Latency:
- With T = 8 + dummy + 2 x bytes, ready pulses exactly 2T + 2 cycles after the grant edge.
- Flash 4-byte read: T = 20, so ready pulses at +42.

Read data:
- Assembled into rdata or instr_data; bytes beyond size are 0.
- The instruction port always reads 4 bytes.
- Both data outputs hold their value until the next completion on the same port.

Boundary conditions:
- A request arriving during DONE is not granted before IDLE.
- data_size 3 is treated as 4 bytes.
- A request whose req drops before ready is undefined and not supported.

Test Plan:
- Flash fetch: instr_addr 0x000100, flash drives nibbles of bytes 0x13, 0x05, 0x00, 0x00 -> CS flash low, out nibbles E, B, 0, 0, 0, 1, 0, 0 -> instr_data 0x00000513, ready at grant + 42.
- RAM B 2-byte write: data_addr 0x1800010, wdata 0x0000BEEF -> cmd 3, 8; address 000010; data nibbles E, F, B, E with oe F; ram_b_select low; no dummy; ready at +26.
- RAM A 1-byte read: addr 0x1000004, input byte 0xA5, RAM_DUMMY 6 -> data_rdata 0x000000A5, oe 0 during the 6 dummy and 2 data nibbles.
- Both requesters asserted together for back-to-back transactions -> grants alternate data, instr, data; CS high at least 2 cycles between transactions.
- Flash write: data_we 1, addr 0x0000040 -> no CS activity, data_ready pulse 2 cycles after grant.
- rst_n low during ADDR of a fetch -> next cycle all selects 1, oe 0, clk 0, no instr_ready pulse; a new fetch then completes normally.
